pipeline_hazard_ctrl: RTL and testbench

Pipeline control block for the 5-stage RISC-V core, the companion to the forwarding unit. It covers the hazards forwarding cannot resolve: load-use stalls, taken-branch flushes, and data-memory wait states with a watchdog. It drives the PC and pipeline-register write enables, flushes and bubbles, and sits alongside the forwarding unit in the core top level.

---
 rtl/pipeline_hazard_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Pipeline control for the 5-stage RISC-V core. It handles the hazards that the
// forwarding unit cannot resolve:
//   - load-use stalls (one bubble into EX),
//   - taken-branch flushes (IF/ID and ID/EX squashed),
//   - data-memory wait states (whole pipe frozen), guarded by a watchdog that
//     parks the block in a sticky error state after MEM_TIMEOUT waits.
//
// Optional feature: define HAZ_PERF_CNT_EN to build the three 32-bit
// performance counters. Without it the counter ports read constant 0.
//
// Parameters:
//   MEM_TIMEOUT     max consecutive memory-wait cycles before error (2..255)
//
// Ports:
//   clk, reset      core clock, synchronous active-high reset
//   if_id_rs1/rs2   source registers of the instruction in ID
//   if_id_use_rs1/2 ID instruction actually reads that source
//   id_ex_rd        destination of the instruction in EX
//   id_ex_memread   EX instruction is a load
//   ex_branch_taken branch/jump resolved taken in EX
//   mem_req         MEM stage accesses data memory
//   mem_ready       data memory completes the access this cycle
//   pc_write, if_id_write, id_ex_write, ex_mem_write   register load enables
//   if_id_flush     IF/ID cleared to NOP at the next edge
//   id_ex_bubble    ID/EX loads zero control signals
//   mem_wb_bubble   MEM/WB loads a NOP
//   mem_err         sticky watchdog error
//   stall_cnt, freeze_cnt, flush_cnt   performance counters (wrap at 2^32)
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  if_id_rs1,
    input  logic [4:0]  if_id_rs2,
    input  logic        if_id_use_rs1,
    input  logic        if_id_use_rs2,
    input  logic [4:0]  id_ex_rd,
    input  logic        id_ex_memread,
    input  logic        ex_branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_write,
    output logic        id_ex_bubble,
    output logic        ex_mem_write,
    output logic        mem_wb_bubble,
    output logic        mem_err,
    output logic [31:0] stall_cnt,
    output logic [31:0] freeze_cnt,
    output logic [31:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FREEZE = 2'd1,
        ERR    = 2'd2
    } state_t;

    // Value of wait_cnt during the MEM_TIMEOUT-th consecutive wait cycle.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_err_q, mem_err_d;

    logic wait_now;
    logic load_use;

    assign wait_now = mem_req & ~mem_ready;
    assign load_use = id_ex_memread & (id_ex_rd != 5'd0) &
                      ((if_id_use_rs1 & (id_ex_rd == if_id_rs1)) |
                       (if_id_use_rs2 & (id_ex_rd == if_id_rs2)));

    // Sticky error is masked while reset is held so the core sees a clean
    // reset state before the clearing edge.
    assign mem_err = mem_err_q & ~reset;

    // Next-state and control outputs.
    // NOTE: every signal written here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_err_d     = mem_err_q;
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_write   = 1'b1;
        id_ex_bubble  = 1'b0;
        ex_mem_write  = 1'b1;
        mem_wb_bubble = 1'b0;

        if (reset) begin
            // Registers keep loading, but every stage is forced to a NOP.
            if_id_flush   = 1'b1;
            id_ex_bubble  = 1'b1;
            mem_wb_bubble = 1'b1;
        end else if (state_q == ERR) begin
            // Parked until reset; all inputs ignored.
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_write  = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (wait_now) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_write  = 1'b0;
            mem_wb_bubble = 1'b1;
            if (state_q == RUN) begin
                state_d    = FREEZE;
                wait_cnt_d = 8'd1;
            end else if (wait_cnt_q == WAIT_LAST) begin
                state_d   = ERR;
                mem_err_d = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + 8'd1;
            end
        end else begin
            // Release cycle of a freeze already follows the lower priorities;
            // a branch held in EX during the freeze flushes here.
            state_d    = RUN;
            wait_cnt_d = 8'd0;
            if (ex_branch_taken) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (load_use) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
            end
        end
    end

    // NOTE: reset is synchronous here, so it sits inside the clocked branch
    // rather than in the sensitivity list; state uses non-blocking updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            wait_cnt_q <= 8'd0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic        active;
    logic        stall_inc, freeze_inc, flush_inc;
    logic [31:0] stall_cnt_q, freeze_cnt_q, flush_cnt_q;

    // Which priority applied this cycle; ERR cycles are never counted.
    assign active     = ~reset & (state_q != ERR);
    assign freeze_inc = active & wait_now;
    assign flush_inc  = active & ~wait_now & ex_branch_taken;
    assign stall_inc  = active & ~wait_now & ~ex_branch_taken & load_use;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q  <= 32'd0;
            freeze_cnt_q <= 32'd0;
            flush_cnt_q  <= 32'd0;
        end else begin
            if (stall_inc)  stall_cnt_q  <= stall_cnt_q + 32'd1;
            if (freeze_inc) freeze_cnt_q <= freeze_cnt_q + 32'd1;
            if (flush_inc)  flush_cnt_q  <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign freeze_cnt = freeze_cnt_q;
    assign flush_cnt  = flush_cnt_q;
`else
    assign stall_cnt  = 32'd0;
    assign freeze_cnt = 32'd0;
    assign flush_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Table of single-cycle hazard vectors followed by hand-written multi-cycle
// sequences (freeze, branch during freeze, watchdog, reset in FREEZE/ERR).
// Expected control patterns are queued when a cycle is driven and compared at
// the falling edge. Counter expectations come from a small model that counts
// the expected patterns; without HAZ_PERF_CNT_EN they are expected to be 0.
// The DUT is built with MEM_TIMEOUT = 4.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    typedef struct {
        logic       reset;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic [4:0] rd;
        logic       memread;
        logic       br;
        logic       req;
        logic       ready;
    } in_t;

    typedef struct {
        in_t        in;
        logic [7:0] exp;
    } vec_t;

    // {pc_write, if_id_write, if_id_flush, id_ex_write,
    //  id_ex_bubble, ex_mem_write, mem_wb_bubble, mem_err}
    localparam logic [7:0] O_NORM   = 8'b1101_0100;
    localparam logic [7:0] O_FLUSH  = 8'b1111_1100;
    localparam logic [7:0] O_STALL  = 8'b0001_1100;
    localparam logic [7:0] O_FREEZE = 8'b0000_0010;
    localparam logic [7:0] O_ERR    = 8'b0000_0011;
    localparam logic [7:0] O_RST    = 8'b1111_1110;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  if_id_rs1, if_id_rs2, id_ex_rd;
    logic        if_id_use_rs1, if_id_use_rs2, id_ex_memread;
    logic        ex_branch_taken, mem_req, mem_ready;
    logic        pc_write, if_id_write, if_id_flush, id_ex_write;
    logic        id_ex_bubble, ex_mem_write, mem_wb_bubble, mem_err;
    logic [31:0] stall_cnt, freeze_cnt, flush_cnt;

    int n_total = 0;
    int n_bad   = 0;

    logic [7:0]  exp_q[$];
    logic [31:0] m_stall = 0, m_freeze = 0, m_flush = 0;
    bit          cnt_valid = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .if_id_rs1      (if_id_rs1),
        .if_id_rs2      (if_id_rs2),
        .if_id_use_rs1  (if_id_use_rs1),
        .if_id_use_rs2  (if_id_use_rs2),
        .id_ex_rd       (id_ex_rd),
        .id_ex_memread  (id_ex_memread),
        .ex_branch_taken(ex_branch_taken),
        .mem_req        (mem_req),
        .mem_ready      (mem_ready),
        .pc_write       (pc_write),
        .if_id_write    (if_id_write),
        .if_id_flush    (if_id_flush),
        .id_ex_write    (id_ex_write),
        .id_ex_bubble   (id_ex_bubble),
        .ex_mem_write   (ex_mem_write),
        .mem_wb_bubble  (mem_wb_bubble),
        .mem_err        (mem_err),
        .stall_cnt      (stall_cnt),
        .freeze_cnt     (freeze_cnt),
        .flush_cnt      (flush_cnt)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    function automatic in_t mk(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic use1, input logic use2, input logic [4:0] rd,
                               input logic memread, input logic br, input logic req,
                               input logic ready);
        in_t r;
        r.reset = rst;  r.rs1 = rs1;   r.rs2 = rs2;   r.use1 = use1; r.use2 = use2;
        r.rd = rd;      r.memread = memread; r.br = br; r.req = req; r.ready = ready;
        return r;
    endfunction

    // Common shorthands.
    function automatic in_t idle();
        return mk(1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic in_t memwait(input logic br, input logic lu);
        return mk(1'b0, 5'd5, 5'd2, 1'b1, 1'b0, 5'd5, lu, br, 1'b1, 1'b0);
    endfunction
    function automatic in_t release_(input logic br, input logic lu);
        return mk(1'b0, 5'd5, 5'd2, 1'b1, 1'b0, 5'd5, lu, br, 1'b1, 1'b1);
    endfunction
    function automatic in_t rst_in();
        return mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    // One clock cycle: drive after the rising edge, compare at the falling edge.
    task automatic step(input string tag, input in_t in, input logic [7:0] want);
        logic [7:0] got;
        logic [7:0] e;
        @(posedge clk);
        #1;
        reset           = in.reset;
        if_id_rs1       = in.rs1;
        if_id_rs2       = in.rs2;
        if_id_use_rs1   = in.use1;
        if_id_use_rs2   = in.use2;
        id_ex_rd        = in.rd;
        id_ex_memread   = in.memread;
        ex_branch_taken = in.br;
        mem_req         = in.req;
        mem_ready       = in.ready;
        exp_q.push_back(want);
        @(negedge clk);
        if (cnt_valid) begin
`ifdef HAZ_PERF_CNT_EN
            check({tag, " stall_cnt"},  stall_cnt,  m_stall);
            check({tag, " freeze_cnt"}, freeze_cnt, m_freeze);
            check({tag, " flush_cnt"},  flush_cnt,  m_flush);
`else
            check({tag, " stall_cnt"},  stall_cnt,  32'd0);
            check({tag, " freeze_cnt"}, freeze_cnt, 32'd0);
            check({tag, " flush_cnt"},  flush_cnt,  32'd0);
`endif
        end
        got = {pc_write, if_id_write, if_id_flush, id_ex_write,
               id_ex_bubble, ex_mem_write, mem_wb_bubble, mem_err};
        e = exp_q.pop_front();
        check({tag, " ctrl"}, {24'd0, got}, {24'd0, e});
        // Counter model: counts which priority the expected pattern represents.
        if (in.reset) begin
            m_stall = 0; m_freeze = 0; m_flush = 0;
            cnt_valid = 1;
        end else if (want == O_STALL)  m_stall++;
        else if (want == O_FREEZE)     m_freeze++;
        else if (want == O_FLUSH)      m_flush++;
    endtask

    vec_t vecs[12];

    initial begin
        // reset, rs1, rs2, use1, use2, rd, memread, br, req, ready
        vecs[0]  = '{mk(0, 5'd1,  5'd2, 1, 1, 5'd3,  1, 0, 0, 0), O_NORM};   // load, no match
        vecs[1]  = '{mk(0, 5'd5,  5'd2, 1, 0, 5'd5,  1, 0, 0, 0), O_STALL};  // load-use via rs1
        vecs[2]  = '{mk(0, 5'd5,  5'd2, 1, 0, 5'd0,  0, 0, 0, 0), O_NORM};   // bubble now in EX
        vecs[3]  = '{mk(0, 5'd0,  5'd0, 1, 1, 5'd0,  1, 0, 0, 0), O_NORM};   // rd = x0 never stalls
        vecs[4]  = '{mk(0, 5'd5,  5'd7, 0, 1, 5'd5,  1, 0, 0, 0), O_NORM};   // rs1 not used
        vecs[5]  = '{mk(0, 5'd1,  5'd9, 1, 1, 5'd9,  1, 0, 0, 0), O_STALL};  // load-use via rs2
        vecs[6]  = '{mk(0, 5'd1,  5'd9, 1, 0, 5'd9,  1, 0, 0, 0), O_NORM};   // rs2 not used
        vecs[7]  = '{mk(0, 5'd5,  5'd2, 1, 1, 5'd5,  0, 0, 0, 0), O_NORM};   // not a load
        vecs[8]  = '{mk(0, 5'd1,  5'd2, 1, 1, 5'd3,  0, 1, 0, 0), O_FLUSH};  // taken branch
        vecs[9]  = '{mk(0, 5'd5,  5'd2, 1, 0, 5'd5,  1, 1, 0, 0), O_FLUSH};  // branch beats load-use
        vecs[10] = '{mk(0, 5'd5,  5'd2, 1, 0, 5'd5,  1, 0, 1, 1), O_STALL};  // mem ready: no wait
        vecs[11] = '{mk(0, 5'd31, 5'd2, 1, 0, 5'd31, 1, 0, 0, 0), O_STALL};  // rd = x31 boundary

        reset = 1'b1; if_id_rs1 = '0; if_id_rs2 = '0; if_id_use_rs1 = 1'b0;
        if_id_use_rs2 = 1'b0; id_ex_rd = '0; id_ex_memread = 1'b0;
        ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;

        step("reset0", rst_in(), O_RST);
        step("reset1", rst_in(), O_RST);

        for (int i = 0; i < 12; i++)
            step($sformatf("vec%0d", i), vecs[i].in, vecs[i].exp);
        step("post_vec", idle(), O_NORM);

        // Memory freeze: three wait cycles, release, back to normal.
        for (int i = 0; i < 3; i++) step($sformatf("frz%0d", i), memwait(0, 0), O_FREEZE);
        step("frz_rel",  release_(0, 0), O_NORM);
        step("frz_idle", idle(), O_NORM);

        // Branch held in EX through a 2-cycle wait flushes only on release.
        for (int i = 0; i < 2; i++) step($sformatf("bfrz%0d", i), memwait(1, 0), O_FREEZE);
        step("bfrz_rel",  release_(1, 0), O_FLUSH);
        step("bfrz_idle", idle(), O_NORM);

        // Load-use pending across a freeze stalls in the release cycle.
        step("lfrz0",    memwait(0, 1), O_FREEZE);
        step("lfrz_rel", release_(0, 1), O_STALL);
        step("lfrz_idle", idle(), O_NORM);

        // MEM_TIMEOUT-1 waits then release: no error.
        for (int i = 0; i < 3; i++) step($sformatf("wd_edge%0d", i), memwait(0, 0), O_FREEZE);
        step("wd_edge_rel", release_(0, 0), O_NORM);

        // Watchdog: six waits, error after the 4th wait edge.
        for (int i = 0; i < 4; i++) step($sformatf("wd%0d", i), memwait(0, 0), O_FREEZE);
        step("wd4", memwait(0, 0), O_ERR);
        step("wd5", memwait(0, 0), O_ERR);
        step("wd_ready",  release_(1, 1), O_ERR);
        step("wd_idle",   idle(), O_ERR);
        step("wd_reset",  rst_in(), O_RST);
        step("wd_after",  idle(), O_NORM);
        step("wd_lu",     vecs[1].in, O_STALL);

        // Reset while frozen takes effect at the same edge.
        step("rf0",     memwait(0, 0), O_FREEZE);
        step("rf1",     memwait(0, 0), O_FREEZE);
        step("rf_rst",  rst_in(), O_RST);
        step("rf_run",  idle(), O_NORM);
        step("rf_wait", memwait(0, 0), O_FREEZE);
        step("rf_rel",  release_(0, 0), O_NORM);
        step("final",   idle(), O_NORM);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
